dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store initiator for DataMem: accepts one load/store request at a time from the execute stage,
//  drives the word-indexed data-memory port and returns sign/zero-extended load data.
//  Sub-word stores (SB/SH) use read-modify-write against the async-read, sync-write memory.
//  Sits between the execute stage and DataMem; the memory needs no change.
// PARAMETERS
//  MEM_BYTES    256  memory size in bytes; byte address >= MEM_BYTES is out of range
//  RANGE_CHECK  1    1: out-of-range access returns resp_err, no memory access; 0: no check
// PORTS
//  clk                input   1   sole clock, rising edge
//  rst                input   1   synchronous, active-high reset
//  req_valid          input   1   request present
//  req_ready          output  1   block can accept a request (high only in IDLE)
//  req_store          input   1   1 = store, 0 = load
//  req_funct3         input   3   000 B, 001 H, 010 W, 100 BU, 101 HU (RISC-V encoding)
//  req_addr           input   32  byte address
//  req_wdata          input   32  store data, right-aligned
//  resp_valid         output  1   response present; held until resp_ready
//  resp_ready         input   1   consumer takes the response
//  resp_rdata         output  32  extended load data; 0 for stores and errors
//  resp_err           output  1   illegal funct3, misaligned (option) or out of range
//  dm_read_addr       output  32  word index = {2'b00, addr_q[31:2]}, registered
//  dm_write_data_rs2  output  32  merged store word, registered
//  dm_write_en        output  1   registered; high for exactly one cycle per store
//  dm_read_data       input   32  async read data from DataMem
// BEHAVIOUR
//  Reset: state=IDLE; req_ready, resp_valid, resp_err, dm_write_en = 0; resp_rdata, dm_* = 0.
//  FSM IDLE -> READ -> WRITE -> RESP -> IDLE; only these four states.
//  IDLE: req_ready=1. Accept on req_valid&req_ready; latch store, funct3, addr, wdata.
//   Error (funct3 011/110/111, store with 100/101, out of range, misaligned w/ option) -> RESP, err=1.
//   Otherwise: SW -> WRITE; any load, SB or SH -> READ.
//  READ: dm_read_addr valid; sample dm_read_data.
//   Load: select byte addr[1:0] / half addr[1], sign- or zero-extend -> RESP.
//   SB/SH: merge wdata[7:0] / wdata[15:0] into the lane; other lanes unchanged -> WRITE.
//  WRITE: dm_write_en=1 for this cycle only, with dm_write_data_rs2 = merged/full word -> RESP.
//  RESP: resp_valid=1; resp_rdata/resp_err stable until resp_ready; then IDLE.
//   No new request is accepted in the RESP cycle.
//  Latency from accept edge to resp_valid:
//   load 2 cycles; SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
//  Lanes are little-endian: byte k = bits [8k+7:8k].
//  rst in any state: IDLE at the next edge, dm_write_en low, pending response dropped.
//   rst during READ of SB/SH therefore produces no memory write.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   H/HU with addr[0]=1, or W with addr[1:0]!=0 -> resp_err=1; no memory read or write.
//  MISALIGN_TRAP_EN undefined:
//   no alignment error; H/HU ignore addr[0]; W ignores addr[1:0] (force-aligned access).
// TESTING  (memory preloaded: word 8=10, word 9=3, word 10=7)
//  LW 0x20 -> resp_rdata=0x0000000A, resp_err=0; resp_valid 2 cycles after accept; dm_write_en never high.
//  SW 0x24 wdata=0xFFFFFF80, then LB 0x24 -> 0xFFFFFF80, then LBU 0x24 -> 0x00000080;
//   dm_write_en high exactly 1 cycle.
//  SB 0x2A wdata=0x123456AB -> word 10 = 0x00AB0007; write 2 cycles after accept; resp_valid at 3.
//  LH 0x21: with MISALIGN_TRAP_EN -> resp_err=1, resp_rdata=0, 1-cycle latency;
//   without it -> resp_rdata=0x0000000A.
//  LW 0x100 with MEM_BYTES=256, RANGE_CHECK=1 -> resp_err=1; funct3=011 -> resp_err=1.
//  resp_ready low 5 cycles -> resp fields stable, req_ready=0;
//   rst asserted in READ of SB 0x20 -> word 8 stays 10, req_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store initiator for DataMem: one request at a time, RMW for SB/SH, extended load data.
// Optional build macro MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into errors.
module dmem_lsu #(
    parameter int MEM_BYTES   = 256,
    parameter int RANGE_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_read_addr,
    output logic [31:0] dm_write_data_rs2,
    output logic        dm_write_en,
    input  logic [31:0] dm_read_data
);

    // state   | meaning
    // S_IDLE  | ready for a request
    // S_READ  | word read: load extract or sub-word merge
    // S_WRITE | single-cycle memory write
    // S_RESP  | response held until resp_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] dm_read_addr_q, dm_read_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        dm_we_q, dm_we_d;

    logic        req_illegal, req_range, req_misalign, req_error;
    logic [4:0]  lane_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] merged;

    always_comb begin
        req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                      || (req_store && req_funct3[2]);
        req_range   = (RANGE_CHECK != 0) && (req_addr >= 32'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
        req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_misalign = 1'b0;
`endif
        req_error = req_illegal || req_range || req_misalign;
    end

    // Byte lane k lives at bits [8k+7:8k]; halves follow addr[1] only.
    always_comb begin
        lane_sh = {addr_lo_q, 3'b000};
        rd_byte = dm_read_data[lane_sh +: 8];
        rd_half = addr_lo_q[1] ? dm_read_data[31:16] : dm_read_data[15:0];
        merged  = dm_read_data;
        if (funct3_q[1:0] == 2'b00) begin
            merged[lane_sh +: 8] = wdata_q[7:0];
        end else if (addr_lo_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        store_d        = store_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
        wdata_d        = wdata_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        dm_read_addr_d = dm_read_addr_q;
        dm_wdata_d     = dm_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    store_d      = req_store;
                    funct3_d     = req_funct3;
                    addr_lo_d    = req_addr[1:0];
                    wdata_d      = req_wdata[15:0];
                    resp_rdata_d = 32'd0;
                    resp_err_d   = req_error;
                    if (req_error) begin
                        state_d = S_RESP;
                    end else begin
                        dm_read_addr_d = {2'b00, req_addr[31:2]};
                        if (req_store && (req_funct3 == 3'b010)) begin
                            dm_wdata_d = req_wdata;
                            state_d    = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (store_q) begin
                    dm_wdata_d = merged;
                    state_d    = S_WRITE;
                end else begin
                    case (funct3_q[1:0])
                        2'b00:   resp_rdata_d = {{24{rd_byte[7] & ~funct3_q[2]}}, rd_byte};
                        2'b01:   resp_rdata_d = {{16{rd_half[15] & ~funct3_q[2]}}, rd_half};
                        default: resp_rdata_d = dm_read_data;
                    endcase
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            default: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        dm_we_d      = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            store_q        <= 1'b0;
            funct3_q       <= 3'd0;
            addr_lo_q      <= 2'd0;
            wdata_q        <= 16'd0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'd0;
            resp_err_q     <= 1'b0;
            dm_read_addr_q <= 32'd0;
            dm_wdata_q     <= 32'd0;
            dm_we_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            store_q        <= store_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            dm_read_addr_q <= dm_read_addr_d;
            dm_wdata_q     <= dm_wdata_d;
            dm_we_q        <= dm_we_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_err          = resp_err_q;
    assign dm_read_addr      = dm_read_addr_q;
    assign dm_write_data_rs2 = dm_wdata_q;
    assign dm_write_en       = dm_we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array reference model, directed cases plus random traffic.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_read_addr;
    logic [31:0] dm_write_data_rs2;
    logic        dm_write_en;
    logic [31:0] dm_read_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:63];
    logic [7:0]  mm  [0:255];

    typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t exp_resp[$];
    wr_t   exp_wr[$];

    dmem_lsu #(.MEM_BYTES(256), .RANGE_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_read_addr(dm_read_addr), .dm_write_data_rs2(dm_write_data_rs2),
        .dm_write_en(dm_write_en), .dm_read_data(dm_read_data)
    );

    always #5 clk = ~clk;

    assign dm_read_data = mem[dm_read_addr[5:0]];
    always @(posedge clk) if (dm_write_en) mem[dm_read_addr[5:0]] <= dm_write_data_rs2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int w);
        return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
    endfunction

    // Reference behaviour in terms of a byte array; updates it for accepted stores.
    function automatic void model(input bit st, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output bit er, output int lat);
        int size;
        int base;
        logic [63:0] v;
        wr_t w;
        er = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (st && f[2]);
        if (a >= 32'd256) er = 1'b1;
        size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        if ((a % size) != 0) er = 1'b1;
`endif
        rd = 32'd0;
        lat = 1;
        if (er) return;
        base = int'(a) - (int'(a) % size);
        if (st) begin
            for (int i = 0; i < size; i++) mm[base + i] = wd[8*i +: 8];
            w.addr = 32'(base / 4);
            w.data = mword(base / 4);
            exp_wr.push_back(w);
            lat = (size == 4) ? 2 : 3;
        end else begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = v | (64'(mm[base + i]) << (8 * i));
            if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
            rd = v[31:0];
            lat = 2;
        end
    endfunction

    // Compare process: every response handshake and every memory write.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid && resp_ready) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                end
            end
            if (dm_write_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("write_addr", dm_read_addr, w.addr);
                    chk("write_data", dm_write_data_rs2, w.data);
                end
            end
        end
    end

    task automatic do_req(input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] got_rd, output logic got_er);
        logic [31:0] erd;
        bit eer;
        int lat, n, wfirst, wcnt, waited;
        resp_t r;
        logic [31:0] hrd;
        logic her;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            got_rd = 32'hx; got_er = 1'bx;
            return;
        end
        req_valid = 1'b1; req_store = st; req_funct3 = f; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(st, f, a, wd, erd, eer, lat);
        r.rdata = erd; r.err = eer;
        exp_resp.push_back(r);
        n = 1; wfirst = -1; wcnt = 0;
        forever begin
            if (dm_write_en) begin
                if (wfirst < 0) wfirst = n;
                wcnt++;
            end
            if (resp_valid || n >= 20) break;
            @(posedge clk); #1;
            n++;
        end
        chk("resp_latency", 32'(n), 32'(lat));
        chk("write_count", 32'(wcnt), (st && !eer) ? 32'd1 : 32'd0);
        if (st && !eer) chk("write_latency", 32'(wfirst), 32'(lat - 1));
        got_rd = resp_rdata; got_er = resp_err;
        hrd = resp_rdata; her = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, hrd);
            chk("hold_err", {31'd0, resp_err}, {31'd0, her});
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[8] = 32'd10; mem[9] = 32'd3; mem[10] = 32'd7;
        for (int i = 0; i < 256; i++) mm[i] = mem[i/4][8*(i%4) +: 8];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_dm_we", {31'd0, dm_write_en}, 32'd0);
        chk("rst_dm_addr", dm_read_addr, 32'd0);
        chk("rst_dm_wdata", dm_write_data_rs2, 32'd0);
        rst = 1'b0;

        do_req(1'b0, 3'b010, 32'h20, 32'd0, 0, rd, er);
        chk("lw_20", rd, 32'h0000000A);
        do_req(1'b1, 3'b010, 32'h24, 32'hFFFFFF80, 0, rd, er);
        do_req(1'b0, 3'b000, 32'h24, 32'd0, 0, rd, er);
        chk("lb_24", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h24, 32'd0, 0, rd, er);
        chk("lbu_24", rd, 32'h00000080);
        do_req(1'b1, 3'b000, 32'h2A, 32'h123456AB, 0, rd, er);
        chk("sb_2a_word", mem[10], 32'h00AB0007);
        do_req(1'b0, 3'b001, 32'h21, 32'd0, 0, rd, er);
`ifdef MISALIGN_TRAP_EN
        chk("lh_21_err", {31'd0, er}, 32'd1);
        chk("lh_21_rdata", rd, 32'd0);
`else
        chk("lh_21_rdata", rd, 32'h0000000A);
`endif
        do_req(1'b0, 3'b010, 32'h100, 32'd0, 0, rd, er);
        chk("lw_100_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 3'b011, 32'h20, 32'd0, 0, rd, er);
        chk("f3_011_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 3'b010, 32'h24, 32'd0, 5, rd, er);
        chk("lw_24_held", rd, 32'hFFFFFF80);

        // Reset during the READ phase of SB 0x20 must drop the write.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        chk("rstread_we", {31'd0, dm_write_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstread_we2", {31'd0, dm_write_en}, 32'd0);
        chk("rstread_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstread_ready0", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rstread_ready1", {31'd0, req_ready}, 32'd1);
        chk("rstread_word8", mem[8], 32'd10);

        for (int t = 0; t < 200; t++) begin
            bit st;
            logic [2:0] f;
            logic [31:0] a;
            st = ($urandom_range(0, 2) == 0);
            f  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
            a  = 32'($urandom_range(0, 271));
            do_req(st, f, a, $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, rd, er);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("write_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
